// File: rtl/spram_fifo.sv
// rtl/spram_fifo.sv - FWFT FIFO on one single-port RAM with a 2-entry prefetch buffer and empty-path bypass
// Optional SPRAM_FIFO_PARITY_EN: stores even parity per RAM word and adds the o_parity_err pulse output.
module spram_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
`ifdef SPRAM_FIFO_PARITY_EN
  output logic                  o_parity_err,
`endif
  output logic [ADDR_WIDTH:0]   o_count
);

`ifdef SPRAM_FIFO_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LVL = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [RAM_W-1:0]      mem [0:(1 << ADDR_WIDTH)-1];
  logic [RAM_W-1:0]      ram_q;
  logic [RAM_W-1:0]      wr_word;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  inflight;
  logic                  live;
  logic [DATA_WIDTH-1:0] buf_data [0:1];
  logic [1:0]            buf_occ;
  logic                  buf_hd;
  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic                  bypass_ok;
  logic                  wr_bypass;
  logic                  wr_ram;
  logic                  ins;
  logic [DATA_WIDTH-1:0] ins_data;

  assign o_rd_valid = (buf_occ != 2'd0);
  assign o_rd_data  = buf_data[buf_hd];
  assign pop        = o_rd_valid & i_rd_ready;

  // Read wins the single port whenever the prefetch buffer would otherwise starve.
  assign rd_issue  = (ram_cnt != '0) &&
                     (({1'b0, buf_occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign bypass_ok = (ram_cnt == '0) && !inflight &&
                     ({1'b0, buf_occ} < (3'd2 + {2'b0, pop}));

  assign o_wr_ready = live && (o_count < DEPTH) && (bypass_ok || !rd_issue);
  assign push       = i_wr_valid & o_wr_ready;
  assign wr_bypass  = push & bypass_ok;
  assign wr_ram     = push & ~bypass_ok;

  // Landing RAM data and a bypass write are mutually exclusive (bypass needs no read in flight).
  assign ins      = inflight | wr_bypass;
  assign ins_data = inflight ? ram_q[DATA_WIDTH-1:0] : i_wr_data;
  assign ram_addr = rd_issue ? rd_ptr : wr_ptr;
  assign cnt_nxt  = o_count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};

`ifdef SPRAM_FIFO_PARITY_EN
  assign wr_word = {^i_wr_data, i_wr_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= inflight & (^ram_q);
    end
  end
`else
  assign wr_word = i_wr_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem[ram_addr] <= wr_word;
    end else if (rd_issue) begin
      ram_q <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live           <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_cnt        <= '0;
      inflight       <= 1'b0;
      buf_occ        <= 2'd0;
      buf_hd         <= 1'b0;
      buf_data[0]    <= '0;
      buf_data[1]    <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
    end else begin
      live     <= 1'b1;
      inflight <= rd_issue;
      if (wr_ram) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_cnt <= ram_cnt + {{ADDR_WIDTH{1'b0}}, wr_ram} - {{ADDR_WIDTH{1'b0}}, rd_issue};

      // Tail slot is head + occupancy (mod 2); with occ=2 and a pop it reuses the slot being vacated.
      if (ins) begin
        buf_data[buf_hd ^ buf_occ[0]] <= ins_data;
      end
      if (pop) begin
        buf_hd <= ~buf_hd;
      end
      buf_occ <= buf_occ + {1'b0, ins} - {1'b0, pop};

      o_count        <= cnt_nxt;
      o_empty        <= (cnt_nxt == '0);
      o_full         <= (cnt_nxt == DEPTH);
      o_almost_full  <= (cnt_nxt >= AF_LVL);
      o_almost_empty <= (cnt_nxt <= AE_LVL);
    end
  end

endmodule

// File: tb/tb_spram_fifo.sv
// tb/tb_spram_fifo.sv - randomized self-checking bench for spram_fifo against a queue reference model
module tb_spram_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_wr_data;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic       o_full;
  logic       o_empty;
  logic       o_almost_full;
  logic       o_almost_empty;
  logic [3:0] o_count;
`ifdef SPRAM_FIFO_PARITY_EN
  logic       o_parity_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] model_q [$];
  logic       acc;
  logic       popd;
  logic       hh;
  logic [7:0] pd;
  logic [7:0] eh;

  always #5 clk = ~clk;

  spram_fifo #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (3),
    .AFULL_THRESH (6),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_wr_data     (i_wr_data),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty),
`ifdef SPRAM_FIFO_PARITY_EN
    .o_parity_err  (o_parity_err),
`endif
    .o_count       (o_count)
  );

  // Drives one cycle, reports handshakes, and advances the model queue.
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                       output logic a, output logic p, output logic [7:0] d,
                       output logic [7:0] head, output logic have);
    @(negedge clk);
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    #1;
    a    = wv & o_wr_ready;
    p    = o_rd_valid & rr;
    d    = o_rd_data;
    have = (model_q.size() != 0);
    head = have ? model_q[0] : 8'h00;
    @(posedge clk);
    if (p && have) void'(model_q.pop_front());
    if (a) model_q.push_back(wd);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_wr_valid = 1'($urandom);
      i_wr_data  = 8'($urandom);
      i_rd_ready = 1'($urandom);
      #1;
      checks++;
      if ({o_rd_valid, o_count, o_empty, o_almost_empty, o_full, o_almost_full, o_wr_ready} !== 10'b0_0000_1_1_0_0_0) begin
        errors++;
        $display("FAIL reset_flags: got v=%b cnt=%0d e=%b ae=%b f=%b af=%b rdy=%b want 0 0 1 1 0 0 0",
                 o_rd_valid, o_count, o_empty, o_almost_empty, o_full, o_almost_full, o_wr_ready);
      end
      checks++;
      if (o_rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_data: got %h want 00", o_rd_data);
      end
`ifdef SPRAM_FIFO_PARITY_EN
      checks++;
      if (o_parity_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_parity_err: got %b want 0", o_parity_err);
      end
`endif
    end
    @(negedge clk);
    rst = 1'b1;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    #1;
    checks++;
    if (o_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready_early: got %b want 0", o_wr_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", o_wr_ready);
    end
    model_q.delete();
  endtask

  task automatic test_bypass();
    cycle(1'b1, 8'hA5, 1'b0, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({acc, o_rd_valid, o_rd_data, o_count, o_empty} !== {1'b1, 1'b1, 8'hA5, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL bypass_first: got acc=%b v=%b d=%h cnt=%0d e=%b want 1 1 a5 1 0",
               acc, o_rd_valid, o_rd_data, o_count, o_empty);
    end
    checks++;
    if (dut.ram_cnt !== 4'd0) begin
      errors++;
      $display("FAIL bypass_ram_untouched: got ram_cnt=%0d want 0", dut.ram_cnt);
    end
    cycle(1'b1, 8'h5A, 1'b1, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({acc, popd, pd} !== {1'b1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL bypass_pushpop: got acc=%b pop=%b d=%h want 1 1 a5", acc, popd, pd);
    end
    checks++;
    if ({o_count, o_rd_valid, o_rd_data} !== {4'd1, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL bypass_count1: got cnt=%0d v=%b d=%h want 1 1 5a", o_count, o_rd_valid, o_rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({popd, pd, o_count, o_empty, o_rd_valid} !== {1'b1, 8'h5A, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bypass_drain: got pop=%b d=%h cnt=%0d e=%b v=%b want 1 5a 0 1 0",
               popd, pd, o_count, o_empty, o_rd_valid);
    end
  endtask

  task automatic test_fill_drain();
    int nxt;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, acc, popd, pd, eh, hh);
      #1;
      checks++;
      if ({acc, o_count, o_almost_full, o_full} !== {1'b1, 4'(i + 1), (i + 1 >= 6), (i + 1 == 8)}) begin
        errors++;
        $display("FAIL fill_%0d: got acc=%b cnt=%0d af=%b f=%b", i, acc, o_count, o_almost_full, o_full);
      end
    end
    @(negedge clk);
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hFF;
    i_rd_ready = 1'b0;
    #1;
    checks++;
    if (o_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b want 0", o_wr_ready);
    end
    cycle(1'b1, 8'hFF, 1'b0, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({acc, o_count} !== {1'b0, 4'd8}) begin
      errors++;
      $display("FAIL full_refuse: got acc=%b cnt=%0d want 0 8", acc, o_count);
    end
    cycle(1'b1, 8'hFF, 1'b1, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({acc, popd, pd, o_count} !== {1'b0, 1'b1, 8'h00, 4'd7}) begin
      errors++;
      $display("FAIL full_pushpop: got acc=%b pop=%b d=%h cnt=%0d want 0 1 00 7", acc, popd, pd, o_count);
    end
    nxt = 1;
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
      cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
      if (popd) begin
        checks++;
        if (pd !== 8'(nxt)) begin
          errors++;
          $display("FAIL drain_order: got %h want %h", pd, 8'(nxt));
        end
        nxt++;
      end
    end
    #1;
    checks++;
    if ({nxt == 8, o_empty, o_count} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL drain_end: got popped_to=%0d e=%b cnt=%0d want 8 1 0", nxt, o_empty, o_count);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] wd;
    int sz;
    wd = 8'h00;
    for (int c = 0; c < 200; c++) begin
      sz = model_q.size();
      cycle(1'b1, wd, 1'($urandom_range(1)), acc, popd, pd, eh, hh);
      if (acc) wd++;
      checks++;
      if (acc && sz == 8) begin
        errors++;
        $display("FAIL stream_ready_full: ready=1 while count=8");
      end
      if (popd) begin
        checks++;
        if (!hh || pd !== eh) begin
          errors++;
          $display("FAIL stream_order: got %h want %h (model has=%b)", pd, eh, hh);
        end
      end
      #1;
      checks++;
      if ({o_count, o_full, o_empty, o_almost_full, o_almost_empty} !==
          {4'(model_q.size()), model_q.size() == 8, model_q.size() == 0,
           model_q.size() >= 6, model_q.size() <= 2}) begin
        errors++;
        $display("FAIL stream_count: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d",
                 o_count, o_full, o_empty, o_almost_full, o_almost_empty, model_q.size());
      end
    end
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
      cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
      if (popd) begin
        checks++;
        if (!hh || pd !== eh) begin
          errors++;
          $display("FAIL stream_drain: got %h want %h", pd, eh);
        end
      end
    end
    #1;
    checks++;
    if ({model_q.size() == 0, o_empty} !== 2'b11) begin
      errors++;
      $display("FAIL stream_drain_end: got model=%0d e=%b want 0 1", model_q.size(), o_empty);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, acc, popd, pd, eh, hh);
    cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({o_count, dut.inflight} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL midop_setup: got cnt=%0d inflight=%b want 5 1", o_count, dut.inflight);
    end
    @(negedge clk);
    rst = 1'b0;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    model_q.delete();
    #1;
    checks++;
    if ({o_count, o_rd_valid, o_wr_ready} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset: got cnt=%0d v=%b rdy=%b want 0 0 0", o_count, o_rd_valid, o_wr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cycle(1'b1, 8'h3C, 1'b0, acc, popd, pd, eh, hh);
    cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
    #1;
    checks++;
    if ({popd, pd, o_count} !== {1'b1, 8'h3C, 4'd0}) begin
      errors++;
      $display("FAIL midop_first_pop: got pop=%b d=%h cnt=%0d want 1 3c 0", popd, pd, o_count);
    end
  endtask

`ifdef SPRAM_FIFO_PARITY_EN
  task automatic test_parity();
    int pulses;
    int got;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, acc, popd, pd, eh, hh);
    dut.mem[dut.rd_ptr] = dut.mem[dut.rd_ptr] ^ 9'h001;
    model_q[2] = model_q[2] ^ 8'h01;
    pulses = 0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 8'h00, 1'b1, acc, popd, pd, eh, hh);
      if (popd) begin
        got++;
        checks++;
        if (!hh || pd !== eh) begin
          errors++;
          $display("FAIL parity_data: got %h want %h", pd, eh);
        end
      end
      #1;
      if (o_parity_err) begin
        pulses++;
        checks++;
        if (o_rd_data !== 8'h13) begin
          errors++;
          $display("FAIL parity_align: head at pulse got %h want 13", o_rd_data);
        end
      end
    end
    checks++;
    if (pulses != 1 || got != 4) begin
      errors++;
      $display("FAIL parity_summary: got pulses=%0d words=%0d want 1 4", pulses, got);
    end
  endtask
`endif

  initial begin
    rst        = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;
    i_rd_ready = 1'b0;
    test_reset();
    test_bypass();
    test_fill_drain();
    test_streaming();
    test_reset_midop();
`ifdef SPRAM_FIFO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
